rgb_stream_source: RTL and testbench

Frame-stream transmitter for the image-processing pipeline. It reads an RGB888 frame from a synchronous-read pixel memory in raster order. It then drives the `rgb_valid` / `rgb_hsync` / `rgb_vsync` / `r` / `g` / `b` stream consumed by `image_process_top`, inserting horizontal and vertical blanking. It is the on-chip replacement for the bench-side stimulus driver, feeding the grayscale → median → Sobel chain from a frame buffer.

---
 rtl/video_pkg.sv | 24 ++
 rtl/raster_counter.sv | 49 ++++
 rtl/rgb_stream_source.sv | 150 +++++++++++++++
 tb/tb_rgb_stream_source.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video-stream definitions: FSM state encoding, pixel word layout and
// the {R,G,B} channel ordering used by the frame-buffer sources.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } vid_state_t;

  localparam int unsigned PIX_DATA_WIDTH = 8;
  localparam int unsigned RGB_WIDTH      = 3 * PIX_DATA_WIDTH;

  // Channel slots within a packed pixel word: R in the MSBs, B in the LSBs.
  localparam int unsigned CH_R = 2;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 0;

  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x/y within the frame plus a running linear
// pixel address, with end-of-line / end-of-frame flags for the sequencer.
module raster_counter #(
  parameter int unsigned WIDTH      = 200,
  parameter int unsigned HEIGHT     = 200,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  end_of_line,
  output logic                  end_of_frame
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign end_of_line  = (x == X_LAST);
  assign end_of_frame = end_of_line && (y == Y_LAST);

  // The address keeps counting across line ends so no y*WIDTH multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + 1'b1;
      if (end_of_line) begin
        x <= '0;
        if (!end_of_frame) y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_stream_source.sv
// Frame-buffer to RGB stream transmitter: raster-order reads with horizontal
// and vertical blanking, re-aligned to the synchronous memory read latency.
module rgb_stream_source #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIDTH      = 200,
  parameter int unsigned HEIGHT     = 200,
  parameter int unsigned H_BLANK    = 16,
  parameter int unsigned V_BLANK    = 64,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    loop,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [3*DATA_WIDTH-1:0] mem_rdata,
  output logic                    rgb_valid,
  output logic                    rgb_hsync,
  output logic                    rgb_vsync,
  output logic [DATA_WIDTH-1:0]   r,
  output logic [DATA_WIDTH-1:0]   g,
  output logic [DATA_WIDTH-1:0]   b
);

  import video_pkg::*;

  localparam int unsigned MAX_BLANK = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BW        = (MAX_BLANK > 1) ? $clog2(MAX_BLANK) : 1;
  localparam logic [BW-1:0] H_LAST  = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] V_LAST  = BW'(V_BLANK - 1);
  localparam int unsigned R_LSB     = chan_lsb(CH_R, DATA_WIDTH);
  localparam int unsigned G_LSB     = chan_lsb(CH_G, DATA_WIDTH);
  localparam int unsigned B_LSB     = chan_lsb(CH_B, DATA_WIDTH);

  vid_state_t    state;
  logic [BW-1:0] blank_cnt;
  logic          blank_last;
  logic          eol;
  logic          eof;
  logic          cnt_clear;
  logic          cnt_advance;
  logic          s1_valid;
  logic          s1_vsync;
  logic          s1_last;

  assign blank_last  = (state == ST_HBLANK) ? (blank_cnt == H_LAST) : (blank_cnt == V_LAST);
  assign cnt_advance = (state == ST_ACTIVE);
  assign cnt_clear   = ((state == ST_IDLE) && start) ||
                       ((state == ST_VBLANK) && blank_last && loop);

  raster_counter #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_raster (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (cnt_clear),
    .advance      (cnt_advance),
    .addr         (mem_addr),
    .end_of_line  (eol),
    .end_of_frame (eof)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      blank_cnt <= '0;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ACTIVE;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (eol) begin
            blank_cnt <= '0;
            mem_rd_en <= 1'b0;
            state     <= eof ? ST_VBLANK : ST_HBLANK;
          end
        end
        ST_HBLANK: begin
          if (blank_last) begin
            blank_cnt <= '0;
            mem_rd_en <= 1'b1;
            state     <= ST_ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        ST_VBLANK: begin
          if (blank_last) begin
            blank_cnt <= '0;
            if (loop) begin
              mem_rd_en <= 1'b1;
              state     <= ST_ACTIVE;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          blank_cnt <= '0;
          busy      <= 1'b0;
          mem_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 carries the qualifiers alongside the memory read; stage 2 joins them with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_last    <= 1'b0;
      rgb_valid  <= 1'b0;
      rgb_hsync  <= 1'b0;
      rgb_vsync  <= 1'b0;
      frame_done <= 1'b0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
    end else begin
      s1_valid   <= (state == ST_ACTIVE);
      s1_vsync   <= (state == ST_ACTIVE) || (state == ST_HBLANK);
      s1_last    <= (state == ST_ACTIVE) && eof;
      rgb_valid  <= s1_valid;
      rgb_hsync  <= s1_valid;
      rgb_vsync  <= s1_vsync;
      frame_done <= s1_last;
      r          <= s1_valid ? mem_rdata[R_LSB +: DATA_WIDTH] : '0;
      g          <= s1_valid ? mem_rdata[G_LSB +: DATA_WIDTH] : '0;
      b          <= s1_valid ? mem_rdata[B_LSB +: DATA_WIDTH] : '0;
    end
  end

endmodule

// File: tb/tb_rgb_stream_source.sv
// Self-checking bench for rgb_stream_source on a 4x3 frame with short blanking.
module tb_rgb_stream_source;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int HB   = 2;
  localparam int VB   = 3;
  localparam int FLEN = W * H + (H - 1) * HB;
  localparam int PER  = FLEN + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        loop = 1'b0;
  logic        busy, frame_done, mem_rd_en;
  logic [15:0] mem_addr;
  logic [23:0] mem_rdata = '0;
  logic        rgb_valid, rgb_hsync, rgb_vsync;
  logic [7:0]  r, g, b;

  int checks = 0;
  int failures = 0;

  rgb_stream_source #(
    .DATA_WIDTH (8),
    .WIDTH      (W),
    .HEIGHT     (H),
    .H_BLANK    (HB),
    .V_BLANK    (VB),
    .ADDR_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .loop       (loop),
    .busy       (busy),
    .frame_done (frame_done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .rgb_valid  (rgb_valid),
    .rgb_hsync  (rgb_hsync),
    .rgb_vsync  (rgb_vsync),
    .r          (r),
    .g          (g),
    .b          (b)
  );

  always #5 clk = ~clk;

  // Synchronous-read pixel memory: addr -> {addr, ~addr, 8'h5A}
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= {mem_addr[7:0], ~mem_addr[7:0], 8'h5A};
  end

  typedef struct {
    logic        valid;
    logic        vsync;
    logic        done;
    logic [7:0]  pr;
    logic [7:0]  pg;
    logic [7:0]  pb;
    logic [15:0] addr;
  } exp_t;

  typedef struct {
    logic        start;
    logic        busy;
    logic        rd;
    logic [15:0] addr;
    logic        valid;
    logic [7:0]  pr;
  } vec_t;

  exp_t exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic exp_t idle_item();
    exp_t e;
    e.valid = 1'b0; e.vsync = 1'b0; e.done = 1'b0;
    e.pr = '0; e.pg = '0; e.pb = '0; e.addr = '0;
    return e;
  endfunction

  // Expected output stream, one entry per cycle after the start edge.
  task automatic build_expected(input int nf);
    exp_t e;
    int a;
    exp_q.delete();
    repeat (2) exp_q.push_back(idle_item());
    for (int f = 0; f < nf; f++) begin
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          a = y * W + x;
          e.valid = 1'b1;
          e.vsync = 1'b1;
          e.done  = (y == H - 1) && (x == W - 1);
          e.pr    = a[7:0];
          e.pg    = ~a[7:0];
          e.pb    = 8'h5A;
          e.addr  = a[15:0];
          exp_q.push_back(e);
        end
        if (y < H - 1) begin
          e = idle_item();
          e.vsync = 1'b1;
          repeat (HB) exp_q.push_back(e);
        end
      end
      repeat (VB) exp_q.push_back(idle_item());
    end
    repeat (3) exp_q.push_back(idle_item());
  endtask

  task automatic run_frames(input int nf, input bit poke);
    exp_t e, nx;
    int len, fd, vs;
    logic [63:0] got, want;
    build_expected(nf);
    len = exp_q.size();
    fd = 0;
    vs = 0;
    repeat ($urandom_range(0, 3)) step();
    start = 1'b1;
    loop  = 1'($urandom);
    step();
    start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      e  = exp_q[c - 1];
      nx = (c + 1 < len) ? exp_q[c + 1] : idle_item();
      got  = {18'd0, busy, mem_rd_en, (nx.valid ? mem_addr : 16'h0),
              rgb_valid, rgb_hsync, rgb_vsync, frame_done, r, g, b};
      want = {18'd0, 1'(c <= nf * PER), nx.valid, (nx.valid ? nx.addr : 16'h0),
              e.valid, e.valid, e.vsync, e.done, e.pr, e.pg, e.pb};
      check($sformatf("stream nf=%0d c=%0d", nf, c), got, want);
      if (frame_done) fd++;
      if (rgb_vsync) vs++;
      if (c <= nf * PER) begin
        if (c % PER == 0) loop = (c / PER < nf);
        else              loop = 1'($urandom);
        start = poke ? ((c == 5) || (c == FLEN + 2)) : ($urandom_range(0, 3) == 0);
      end else begin
        start = 1'b0;
        loop  = 1'($urandom);
      end
      step();
    end
    start = 1'b0;
    loop  = 1'b0;
    check($sformatf("frame_done count nf=%0d", nf), 64'(fd), 64'(nf));
    check($sformatf("vsync cycles nf=%0d", nf), 64'(vs), 64'(nf * FLEN));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {24'd0, busy, frame_done, mem_rd_en, rgb_valid, rgb_hsync, rgb_vsync,
                 r, g, b, mem_addr}, 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int n, pix, fd;

    // Control-path vectors for the opening of a frame; entry i is applied, then checked after the edge.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 8'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 8'd2};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 16'd4, 1'b1, 8'd3};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'd4, 1'b0, 8'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 8'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 16'd6, 1'b1, 8'd4};

    #1;
    check_all_zero("reset state");
    repeat (2) step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start;
      step();
      check($sformatf("table vec %0d", i),
            {38'd0, busy, mem_rd_en, mem_addr, rgb_valid, r},
            {38'd0, tbl[i].busy, tbl[i].rd, tbl[i].addr, tbl[i].valid, tbl[i].pr});
    end
    start = 1'b0;

    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("busy falls after table frame", 64'(busy), 64'd0);

    run_frames(1, 1'b0);
    run_frames(1, 1'b1);
    run_frames(2, 1'b0);
    for (int k = 0; k < 3; k++) run_frames(int'($urandom_range(1, 3)), 1'b0);

    // Abort at the 6th pixel of a frame
    start = 1'b1;
    step();
    start = 1'b0;
    pix = 0;
    fd = 0;
    for (int c = 0; c < 60 && pix < 6; c++) begin
      step();
      if (rgb_valid) pix++;
      if (frame_done) fd++;
    end
    check("reached 6th pixel", {48'd0, 8'(pix), r}, {48'd0, 8'd6, 8'd5});
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async reset mid-frame");
    repeat (2) begin
      step();
      if (frame_done) fd++;
    end
    check_all_zero("held in reset");
    check("no frame_done on abort", 64'(fd), 64'd0);
    rst_n = 1'b1;
    step();
    check_all_zero("idle after reset release");
    run_frames(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
